// File: rtl/video_gate_if.sv
// Pixel-domain bus between the video generator, video_gate and the VGA output pins.
interface video_gate_if #(
  parameter int DW = 8
);
  logic          ce_pix;
  logic [DW-1:0] video;
  logic          HBlank;
  logic          VBlank;
  logic          HSync;
  logic          VSync;
  logic [2:0]    chan_req;

  logic [DW-1:0] r_out;
  logic [DW-1:0] g_out;
  logic [DW-1:0] b_out;
  logic          hs_out;
  logic          vs_out;
  logic          de_out;
  logic          ce_out;
  logic          busy;

  modport master (
    output ce_pix, video, HBlank, VBlank, HSync, VSync, chan_req,
    input  r_out, g_out, b_out, hs_out, vs_out, de_out, ce_out, busy
  );

  modport slave (
    input  ce_pix, video, HBlank, VBlank, HSync, VSync, chan_req,
    output r_out, g_out, b_out, hs_out, vs_out, de_out, ce_out, busy
  );
endinterface

// File: rtl/video_gate.sv
// Gates luminance onto R/G/B per channel mask, switching masks only at frame starts.
// Define VIDEO_GATE_FADE_EN for a frame-stepped fade-out/fade-in around each mask change.
module video_gate #(
  parameter int DW        = 8,
  parameter int FADE_LOG2 = 3
) (
  input logic         clk,
  input logic         reset,
  video_gate_if.slave vif
);

  localparam int LW = FADE_LOG2 + 1;
  localparam int PW = DW + FADE_LOG2 + 1;
  localparam logic [LW-1:0] LVL_MAX = LW'(1 << FADE_LOG2);

  logic          vs_prev_q, vs_prev_d;
  logic [2:0]    mask_q, mask_d;
  logic [DW-1:0] r_q, r_d;
  logic [DW-1:0] g_q, g_d;
  logic [DW-1:0] b_q, b_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          de_q, de_d;

  logic          fb;
  logic          de_in;
  logic [LW-1:0] level_cur;
  logic [PW-1:0] prod;
  logic [DW-1:0] scaled;

  // Frame boundary: VSync rising edge as seen on pixel strobes only.
  assign fb    = vif.ce_pix & vif.VSync & ~vs_prev_q;
  assign de_in = ~(vif.HBlank | vif.VBlank);

`ifdef VIDEO_GATE_FADE_EN
  typedef enum logic [1:0] {
    IDLE,
    FADE_OUT,
    FADE_IN
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] level_q, level_d;
  logic          busy_q;

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    mask_d  = mask_q;
    if (fb) begin
      unique case (state_q)
        IDLE: begin
          if (vif.chan_req != mask_q) begin
            state_d = FADE_OUT;
            level_d = LVL_MAX - 1'b1;
          end
        end
        FADE_OUT: begin
          level_d = level_q - 1'b1;
          // The request seen at the frame that hits black wins, even if it reverted.
          if (level_q == LW'(1)) begin
            mask_d  = vif.chan_req;
            state_d = FADE_IN;
          end
        end
        FADE_IN: begin
          level_d = level_q + 1'b1;
          if (level_q == LVL_MAX - 1'b1) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          level_d = LVL_MAX;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      level_q <= LVL_MAX;
      busy_q  <= 1'b0;
    end else if (vif.ce_pix) begin
      state_q <= state_d;
      level_q <= level_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign level_cur = level_q;
  assign vif.busy  = busy_q;
`else
  always_comb begin
    mask_d = mask_q;
    if (fb && (vif.chan_req != mask_q)) begin
      mask_d = vif.chan_req;
    end
  end

  assign level_cur = LVL_MAX;
  assign vif.busy  = 1'b0;
`endif

  always_comb begin
    prod      = PW'(vif.video) * PW'(level_cur);
    scaled    = DW'(prod >> FADE_LOG2);
    r_d       = (de_in && mask_q[2]) ? scaled : '0;
    g_d       = (de_in && mask_q[1]) ? scaled : '0;
    b_d       = (de_in && mask_q[0]) ? scaled : '0;
    hs_d      = vif.HSync;
    vs_d      = vif.VSync;
    de_d      = de_in;
    vs_prev_d = vif.VSync;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_prev_q <= 1'b0;
      mask_q    <= '1;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      de_q      <= 1'b0;
    end else if (vif.ce_pix) begin
      vs_prev_q <= vs_prev_d;
      mask_q    <= mask_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      de_q      <= de_d;
    end
  end

  assign vif.r_out  = r_q;
  assign vif.g_out  = g_q;
  assign vif.b_out  = b_q;
  assign vif.hs_out = hs_q;
  assign vif.vs_out = vs_q;
  assign vif.de_out = de_q;
  assign vif.ce_out = vif.ce_pix;

endmodule

// File: tb/tb_video_gate.sv
// Self-checking bench for video_gate; fade sequences run when VIDEO_GATE_FADE_EN is defined.
module tb_video_gate;

  localparam int DW = 8;
  localparam int FL = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  video_gate_if #(.DW(DW)) vif ();

  video_gate #(.DW(DW), .FADE_LOG2(FL)) dut (
    .clk  (clk),
    .reset(reset),
    .vif  (vif)
  );

  typedef struct {
    logic [7:0] r, g, b;
    logic       hs, vs, de, busy;
    string      nm;
  } exp_t;

  typedef struct {
    logic [7:0] video;
    logic       hb, vb, hs, vs;
    logic [2:0] req;
    logic [7:0] r, g, b;
    logic       hso, vso, deo;
  } vec_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] pr, pg, pb;

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] r, g, b, input logic hs, vs, de, busy,
                              input string nm);
    exp_t e;
    e.r = r; e.g = g; e.b = b; e.hs = hs; e.vs = vs; e.de = de; e.busy = busy; e.nm = nm;
    return e;
  endfunction

  task automatic strobe(input logic [7:0] v, input logic hb, vb, hs, vs,
                        input logic [2:0] req, input exp_t e);
    exp_t got;
    @(negedge clk);
    vif.video = v; vif.HBlank = hb; vif.VBlank = vb;
    vif.HSync = hs; vif.VSync = vs; vif.chan_req = req;
    vif.ce_pix = 1'b1;
    sb.push_back(e);
    #1 chk1("ce_out_hi", vif.ce_out, 1'b1);
    @(posedge clk);
    #1 vif.ce_pix = 1'b0;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      got = sb.pop_front();
      chk8({got.nm, "_r"}, vif.r_out, got.r);
      chk8({got.nm, "_g"}, vif.g_out, got.g);
      chk8({got.nm, "_b"}, vif.b_out, got.b);
      chk1({got.nm, "_hs"}, vif.hs_out, got.hs);
      chk1({got.nm, "_vs"}, vif.vs_out, got.vs);
      chk1({got.nm, "_de"}, vif.de_out, got.de);
      chk1({got.nm, "_busy"}, vif.busy, got.busy);
    end
    chk1("ce_out_lo", vif.ce_out, 1'b0);
    repeat (3) @(posedge clk);
  endtask

  // One frame: the fb strobe still shows the old picture, the next strobe the new one.
  task automatic frame(input logic [2:0] req, input logic [7:0] r, g, b, input logic bsy,
                       input string nm);
    strobe(8'h80, 1'b0, 1'b0, 1'b0, 1'b1, req, mk(pr, pg, pb, 1'b0, 1'b1, 1'b1, bsy, {nm, "_fb"}));
    strobe(8'h80, 1'b0, 1'b0, 1'b0, 1'b0, req, mk(r, g, b, 1'b0, 1'b0, 1'b1, bsy, nm));
    pr = r; pg = g; pb = b;
  endtask

  task automatic check_reset_state(input string nm);
    chk8({nm, "_r"}, vif.r_out, 8'h00);
    chk8({nm, "_g"}, vif.g_out, 8'h00);
    chk8({nm, "_b"}, vif.b_out, 8'h00);
    chk1({nm, "_hs"}, vif.hs_out, 1'b0);
    chk1({nm, "_vs"}, vif.vs_out, 1'b0);
    chk1({nm, "_de"}, vif.de_out, 1'b0);
    chk1({nm, "_busy"}, vif.busy, 1'b0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vt[8];
    vt[0] = '{8'h80, 0, 0, 0, 0, 3'b111, 8'h80, 8'h80, 8'h80, 0, 0, 1};
    vt[1] = '{8'hFF, 1, 0, 1, 0, 3'b111, 8'h00, 8'h00, 8'h00, 1, 0, 0};
    vt[2] = '{8'h33, 0, 1, 0, 1, 3'b111, 8'h00, 8'h00, 8'h00, 0, 1, 0};
    vt[3] = '{8'h01, 0, 0, 0, 1, 3'b111, 8'h01, 8'h01, 8'h01, 0, 1, 1};
    vt[4] = '{8'hFF, 0, 0, 0, 0, 3'b111, 8'hFF, 8'hFF, 8'hFF, 0, 0, 1};
    vt[5] = '{8'h00, 0, 0, 0, 0, 3'b111, 8'h00, 8'h00, 8'h00, 0, 0, 1};
    vt[6] = '{8'h5A, 0, 0, 1, 0, 3'b111, 8'h5A, 8'h5A, 8'h5A, 1, 0, 1};
    vt[7] = '{8'h5A, 0, 0, 0, 0, 3'b111, 8'h5A, 8'h5A, 8'h5A, 0, 0, 1};

    reset = 1'b1;
    vif.ce_pix = 1'b0; vif.video = '0; vif.HBlank = 1'b0; vif.VBlank = 1'b0;
    vif.HSync = 1'b0; vif.VSync = 1'b0; vif.chan_req = 3'b111;
    repeat (3) @(posedge clk);
    #1 check_reset_state("reset");
    @(negedge clk) reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      strobe(vt[i].video, vt[i].hb, vt[i].vb, vt[i].hs, vt[i].vs, vt[i].req,
             mk(vt[i].r, vt[i].g, vt[i].b, vt[i].hso, vt[i].vso, vt[i].deo, 1'b0,
                $sformatf("vec%0d", i)));
    end

    // ce_pix low: nothing may move even with every input changed
    @(negedge clk);
    vif.video = 8'h11; vif.HBlank = 1'b1; vif.HSync = 1'b1; vif.VSync = 1'b1;
    vif.chan_req = 3'b000;
    repeat (4) @(posedge clk);
    #1;
    chk8("freeze_r", vif.r_out, 8'h5A);
    chk8("freeze_b", vif.b_out, 8'h5A);
    chk1("freeze_hs", vif.hs_out, 1'b0);
    chk1("freeze_de", vif.de_out, 1'b1);

`ifdef VIDEO_GATE_FADE_EN
    strobe(8'h80, 0, 0, 0, 0, 3'b100, mk(8'h80, 8'h80, 8'h80, 0, 0, 1, 0, "midreq"));
    pr = 8'h80; pg = 8'h80; pb = 8'h80;
    for (int l = 7; l >= 1; l--) frame(3'b100, 8'(l * 16), 8'(l * 16), 8'(l * 16), 1'b1, "fo");
    frame(3'b100, 8'h00, 8'h00, 8'h00, 1'b1, "fo0");
    for (int l = 1; l <= 7; l++) frame(3'b100, 8'(l * 16), 8'h00, 8'h00, 1'b1, "fi");
    frame(3'b100, 8'h80, 8'h00, 8'h00, 1'b0, "fi8");
    frame(3'b100, 8'h80, 8'h00, 8'h00, 1'b0, "idle");

    for (int l = 7; l >= 5; l--) frame(3'b001, 8'(l * 16), 8'h00, 8'h00, 1'b1, "fo_b");
    for (int l = 4; l >= 1; l--) frame(3'b010, 8'(l * 16), 8'h00, 8'h00, 1'b1, "fo_late");
    frame(3'b010, 8'h00, 8'h00, 8'h00, 1'b1, "late0");
    for (int l = 1; l <= 7; l++) frame(3'b010, 8'h00, 8'(l * 16), 8'h00, 1'b1, "fi_g");
    frame(3'b010, 8'h00, 8'h80, 8'h00, 1'b0, "fi_g8");

    frame(3'b100, 8'h00, 8'h70, 8'h00, 1'b1, "rv_start");
    for (int l = 6; l >= 1; l--) frame(3'b010, 8'h00, 8'(l * 16), 8'h00, 1'b1, "rv_fo");
    frame(3'b010, 8'h00, 8'h00, 8'h00, 1'b1, "rv0");
    for (int l = 1; l <= 7; l++) frame(3'b010, 8'h00, 8'(l * 16), 8'h00, 1'b1, "rv_fi");
    frame(3'b010, 8'h00, 8'h80, 8'h00, 1'b0, "rv8");

    for (int l = 7; l >= 1; l--) frame(3'b111, 8'h00, 8'(l * 16), 8'h00, 1'b1, "all_fo");
    frame(3'b111, 8'h00, 8'h00, 8'h00, 1'b1, "all0");
    for (int l = 1; l <= 3; l++) frame(3'b111, 8'(l * 16), 8'(l * 16), 8'(l * 16), 1'b1, "all_fi");
`else
    strobe(8'h80, 0, 0, 0, 0, 3'b001, mk(8'h80, 8'h80, 8'h80, 0, 0, 1, 0, "nf_mid"));
    strobe(8'h80, 0, 0, 0, 1, 3'b001, mk(8'h80, 8'h80, 8'h80, 0, 1, 1, 0, "nf_fb"));
    strobe(8'h80, 0, 0, 0, 1, 3'b111, mk(8'h00, 8'h00, 8'h80, 0, 1, 1, 0, "nf_hold"));
    strobe(8'h80, 0, 0, 0, 0, 3'b111, mk(8'h00, 8'h00, 8'h80, 0, 0, 1, 0, "nf_blue"));
    strobe(8'hC3, 0, 0, 0, 0, 3'b111, mk(8'h00, 8'h00, 8'hC3, 0, 0, 1, 0, "nf_blue2"));
    strobe(8'h80, 0, 0, 0, 1, 3'b111, mk(8'h00, 8'h00, 8'h80, 0, 1, 1, 0, "nf_fb2"));
    strobe(8'h80, 0, 0, 0, 0, 3'b111, mk(8'h80, 8'h80, 8'h80, 0, 0, 1, 0, "nf_all"));
    strobe(8'h80, 0, 0, 0, 0, 3'b010, mk(8'h80, 8'h80, 8'h80, 0, 0, 1, 0, "nf_mid2"));
`endif

    // Synchronous reset with ce_pix low still clears everything
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1 check_reset_state("midreset");
    @(negedge clk) reset = 1'b0;
    strobe(8'h80, 0, 0, 0, 0, 3'b111, mk(8'h80, 8'h80, 8'h80, 0, 0, 1, 0, "post_reset"));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
